// File: rtl/vga_scan_pkg.sv
// vga_scan_pkg
//   Shared constants for the VGA scan generator: default 640x480@60 timing,
//   the derived line/frame totals, the coordinate width and a small helper
//   used to decode half-open counter windows.
//   Optional feature macro used by the top level: VGA_SCAN_FRAME_CNT_EN.
package vga_scan_pkg;

    localparam int COORD_W = 11;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= v < hi.
    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        return (v >= coord_t'(lo)) && (v < coord_t'(hi));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Wrap counter for one raster axis (horizontal or vertical).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (count -> 0)
//     en        : advance the count on this clock
//     cnt       : current position, 0..TOTAL-1
//     tc        : cnt is at TOTAL-1 (next enabled clock wraps to 0)
//     vis_on    : cnt < ACTIVE
//     sync_on   : cnt in [SYNC_START, SYNC_END)
module vga_axis_counter
    import vga_scan_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
    parameter int SYNC_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   tc,
    output logic   vis_on,
    output logic   sync_on
);

    coord_t cnt_q;
    coord_t cnt_d;
    logic   tc_s;

    assign tc_s = (cnt_q == coord_t'(TOTAL - 1));

    // Next count: hold, increment, or wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (tc_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + coord_t'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_s;
    assign vis_on  = (cnt_q < coord_t'(ACTIVE));
    assign sync_on = in_window(cnt_q, SYNC_START, SYNC_END);

endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator
//   VGA raster timing generator (640x480@60 by default). Divides the system
//   clock down to a pixel strobe, scans x/y for the renderer and registers the
//   renderer colour together with hsync/vsync so the connector pins change on
//   the same edge.
//   Ports:
//     clk, rst            : system clock, synchronous active-high reset
//     x, y                : current pixel/line position presented to renderer
//     pix_en              : one-clock strobe; x/y advance on that clock
//     r_in, g_in, b_in    : renderer colour for the current x/y
//     vga_r, vga_g, vga_b : registered colour (black outside the visible area)
//     vga_hs, vga_vs      : registered syncs, asserted level = SYNC_POL
//     active              : registered visible-area flag aligned with vga_*
//   Optional (macro VGA_SCAN_FRAME_CNT_EN):
//     frame_start         : one-clock pulse when x and y both wrap to 0
//     frame_cnt           : 16-bit wrapping frame counter
module vga_scan_generator
    import vga_scan_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pix_en,
    input  logic [2:0]         r_in,
    input  logic [2:0]         g_in,
    input  logic [2:0]         b_in,
    output logic [2:0]         vga_r,
    output logic [2:0]         vga_g,
    output logic [2:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
`ifdef VGA_SCAN_FRAME_CNT_EN
    output logic               frame_start,
    output logic [15:0]        frame_cnt,
`endif
    output logic               active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A one-bit divider still works for CLK_DIV=1: it simply stays at 0.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [DIV_W-1:0] div_t;

    div_t       div_q, div_d;
    logic       pix_en_q, pix_en_d;
    logic [2:0] vga_r_q, vga_r_d;
    logic [2:0] vga_g_q, vga_g_d;
    logic [2:0] vga_b_q, vga_b_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic       active_q, active_d;

    coord_t     x_cnt, y_cnt;
    logic       h_tc, h_vis, h_sync_on;
    logic       v_vis, v_sync_on;
    logic       vis;
`ifdef VGA_SCAN_FRAME_CNT_EN
    logic       v_tc;
`else
    logic       v_tc_unused;
`endif

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en_q),
        .cnt     (x_cnt),
        .tc      (h_tc),
        .vis_on  (h_vis),
        .sync_on (h_sync_on)
    );

    // The line counter only steps on the pixel that ends a line.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en_q & h_tc),
        .cnt     (y_cnt),
`ifdef VGA_SCAN_FRAME_CNT_EN
        .tc      (v_tc),
`else
        .tc      (v_tc_unused),
`endif
        .vis_on  (v_vis),
        .sync_on (v_sync_on)
    );

    assign vis = h_vis & v_vis;

    // Pixel divider; pix_en is registered from the next divider value so it
    // is high exactly while the divider sits at CLK_DIV-1.
    always_comb begin
        if (div_q == div_t'(CLK_DIV - 1)) begin
            div_d = '0;
        end else begin
            div_d = div_q + div_t'(1);
        end
        pix_en_d = (div_d == div_t'(CLK_DIV - 1));
    end

    // Output stage: colour and syncs sampled from the current x/y decode on
    // the pixel strobe, so everything lags x/y by exactly one pixel.
    always_comb begin
        vga_r_d  = vga_r_q;
        vga_g_d  = vga_g_q;
        vga_b_d  = vga_b_q;
        vga_hs_d = vga_hs_q;
        vga_vs_d = vga_vs_q;
        active_d = active_q;
        if (pix_en_q) begin
            vga_r_d  = vis ? r_in : 3'd0;
            vga_g_d  = vis ? g_in : 3'd0;
            vga_b_d  = vis ? b_in : 3'd0;
            vga_hs_d = h_sync_on ? SYNC_POL : ~SYNC_POL;
            vga_vs_d = v_sync_on ? SYNC_POL : ~SYNC_POL;
            active_d = vis;
        end else begin
            active_d = active_q;
        end
    end

    // Divider and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            vga_r_q  <= 3'd0;
            vga_g_q  <= 3'd0;
            vga_b_q  <= 3'd0;
            vga_hs_q <= ~SYNC_POL;
            vga_vs_q <= ~SYNC_POL;
            active_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            active_q <= active_d;
        end
    end

`ifdef VGA_SCAN_FRAME_CNT_EN
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_wrap;

    assign frame_wrap = pix_en_q & h_tc & v_tc;

    // Frame pulse and counter step on the edge where x and y both wrap.
    always_comb begin
        frame_start_d = frame_wrap;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
`endif

    assign x      = x_cnt;
    assign y      = y_cnt;
    assign pix_en = pix_en_q;
    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;
    assign active = active_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Directed bench for vga_scan_generator.
//   dut_a: default 640x480 timing, CLK_DIV=2, active-low syncs.
//   dut_b: miniature 16x9 raster, CLK_DIV=1, active-high syncs, so a whole
//          frame (wrap, vsync window) fits in a few hundred clocks.
module tb_vga_scan_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  r_in, g_in, b_in;

    logic [10:0] x_a, y_a, x_b, y_b;
    logic        pix_en_a, pix_en_b;
    logic [2:0]  vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
    logic        hs_a, vs_a, active_a, hs_b, vs_b, active_b;
`ifdef VGA_SCAN_FRAME_CNT_EN
    logic        frame_start_a, frame_start_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

    int checks = 0;
    int errors = 0;

    vga_scan_generator dut_a (
        .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .pix_en(pix_en_a),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .vga_hs(hs_a), .vga_vs(vs_a),
`ifdef VGA_SCAN_FRAME_CNT_EN
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a),
`endif
        .active(active_a)
    );

    vga_scan_generator #(
        .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .pix_en(pix_en_b),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .vga_hs(hs_b), .vga_vs(vs_b),
`ifdef VGA_SCAN_FRAME_CNT_EN
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b),
`endif
        .active(active_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hs_cnt, hs_first, act_cnt, col_ok, blank_bad, xpos_bad, vs_low;
        int vs_cnt, vs_first, pe_low;
        logic [10:0] x_save, y_save;

        rst_a = 1'b1; rst_b = 1'b1;
        r_in = 3'd7; g_in = 3'd5; b_in = 3'd2;
        repeat (3) tick();

        // ---------------- reset state ----------------
        check("a_rst_x", x_a, 0);
        check("a_rst_y", y_a, 0);
        check("a_rst_pix_en", pix_en_a, 0);
        check("a_rst_r", vga_r_a, 0);
        check("a_rst_hs", hs_a, 1);
        check("a_rst_vs", vs_a, 1);
        check("a_rst_active", active_a, 0);
        check("b_rst_hs", hs_b, 0);
        check("b_rst_vs", vs_b, 0);
        check("b_rst_pix_en", pix_en_b, 0);
`ifdef VGA_SCAN_FRAME_CNT_EN
        check("a_rst_frame_cnt", frame_cnt_a, 0);
        check("a_rst_frame_start", frame_start_a, 0);
`endif

        // ---------------- first pixels, CLK_DIV=2 ----------------
        rst_a = 1'b0;
        tick();
        check("a_first_pix_en", pix_en_a, 1);
        check("a_first_x", x_a, 0);
        tick();
        check("a_x_after_pix", x_a, 1);
        check("a_pix_en_low", pix_en_a, 0);
        check("a_r_pixel0", vga_r_a, 7);
        check("a_g_pixel0", vga_g_a, 5);
        check("a_b_pixel0", vga_b_a, 2);
        check("a_active_pixel0", active_a, 1);
        check("a_hs_pixel0", hs_a, 1);

        // ---------------- end of line 0 ----------------
        n = 0;
        while (!(x_a == 11'd799 && pix_en_a == 1'b1) && n < 4000) begin
            tick();
            n++;
        end
        check("a_reach_x799", (n < 4000), 1);
        check("a_y_at_x799", y_a, 0);
        tick();
        check("a_wrap_x", x_a, 0);
        check("a_wrap_y", y_a, 1);
        check("a_active_px799", active_a, 0);
        check("a_r_px799", vga_r_a, 0);

        // ---------------- one full line (y=1) ----------------
        hs_cnt = 0; hs_first = -1; act_cnt = 0; col_ok = 0;
        blank_bad = 0; xpos_bad = 0; vs_low = 0;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (x_a != 11'(k) || pix_en_a != 1'b1) xpos_bad++;
            tick();
            // outputs now describe pixel k
            if (hs_a == 1'b0) begin
                if (hs_first < 0) hs_first = k;
                hs_cnt++;
            end
            if (vs_a == 1'b0) vs_low++;
            if (active_a) begin
                act_cnt++;
                if (vga_r_a == 3'd7 && vga_g_a == 3'd5 && vga_b_a == 3'd2) col_ok++;
            end else if ((vga_r_a | vga_g_a | vga_b_a) != 3'd0) begin
                blank_bad++;
            end
        end
        check("a_hs_low_pixels", hs_cnt, 96);
        check("a_hs_first_pixel", hs_first, 656);
        check("a_active_pixels", act_cnt, 640);
        check("a_colour_pixels", col_ok, 640);
        check("a_blank_nonblack", blank_bad, 0);
        check("a_x_sequence_bad", xpos_bad, 0);
        check("a_vs_low_line1", vs_low, 0);
        check("a_line_end_x", x_a, 0);
        check("a_line_end_y", y_a, 2);

        // ---------------- reset mid-line ----------------
        n = 0;
        while (x_a != 11'd300 && n < 1000) begin
            tick();
            n++;
        end
        check("a_reach_x300", (n < 1000), 1);
        rst_a = 1'b1;
        tick();
        check("a_mid_rst_x", x_a, 0);
        check("a_mid_rst_y", y_a, 0);
        check("a_mid_rst_pix_en", pix_en_a, 0);
        check("a_mid_rst_hs", hs_a, 1);
        check("a_mid_rst_vs", vs_a, 1);
        check("a_mid_rst_r", vga_r_a, 0);
        check("a_mid_rst_active", active_a, 0);
        rst_a = 1'b0;
        tick();
        tick();
        check("a_resume_x", x_a, 1);
        check("a_resume_y", y_a, 0);
        check("a_resume_r", vga_r_a, 7);

        // ---------------- small raster, CLK_DIV=1, full frame ----------------
        r_in = 3'd3; g_in = 3'd6; b_in = 3'd1;
        rst_b = 1'b0;
        tick();
        check("b_first_pix_en", pix_en_b, 1);
        check("b_first_x", x_b, 0);
        vs_cnt = 0; vs_first = -1; hs_cnt = 0; act_cnt = 0; pe_low = 0;
        blank_bad = 0; col_ok = 0;
        x_save = '0; y_save = '0;
        for (int p = 0; p < 144; p++) begin
            if (p == 143) begin
                x_save = x_b;
                y_save = y_b;
            end
            tick();
            // outputs now describe pixel p = y*16 + x
            if (pix_en_b != 1'b1) pe_low++;
            if (vs_b == 1'b1) begin
                if (vs_first < 0) vs_first = p;
                vs_cnt++;
            end
            if (hs_b == 1'b1) hs_cnt++;
            if (active_b) begin
                act_cnt++;
                if (vga_r_b == 3'd3 && vga_g_b == 3'd6 && vga_b_b == 3'd1) col_ok++;
            end else if ((vga_r_b | vga_g_b | vga_b_b) != 3'd0) begin
                blank_bad++;
            end
`ifdef VGA_SCAN_FRAME_CNT_EN
            if (p == 143) begin
                check("b_frame_start_pulse", frame_start_b, 1);
                check("b_frame_cnt_1", frame_cnt_b, 1);
            end
`endif
        end
        check("b_last_x", x_save, 15);
        check("b_last_y", y_save, 8);
        check("b_frame_wrap_x", x_b, 0);
        check("b_frame_wrap_y", y_b, 0);
        check("b_pix_en_every_clock", pe_low, 0);
        check("b_vs_pixels", vs_cnt, 32);
        check("b_vs_first_pixel", vs_first, 80);
        check("b_hs_pixels", hs_cnt, 27);
        check("b_active_pixels", act_cnt, 32);
        check("b_colour_pixels", col_ok, 32);
        check("b_blank_nonblack", blank_bad, 0);
        tick();
        check("b_x_after_wrap", x_b, 1);
`ifdef VGA_SCAN_FRAME_CNT_EN
        check("b_frame_start_single", frame_start_b, 0);
        check("b_frame_cnt_hold", frame_cnt_b, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_generator.md
Name: vga_scan_generator

Overview:
- Generates VGA 640x480@60 raster timing: pixel coordinates x/y feeding the on-screen renderer, plus hsync/vsync.
- Registers the renderer's combinational 3-bit r/g/b together with the syncs, so pin-level outputs are aligned and glitch-free.
- Sits between the system clock domain and the VGA connector: upstream of the renderer for x/y, downstream for colour.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch (H_TOTAL = 800).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch (V_TOTAL = 525).
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active low).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- x  out  11  current horizontal pixel count, 0..H_TOTAL-1
- y  out  11  current line count, 0..V_TOTAL-1
- pix_en  out  1  one-clock strobe; x/y advance on the clock where pix_en=1
- r_in, g_in, b_in  in  3 each  colour from renderer for current x/y
- vga_r, vga_g, vga_b  out  3 each  registered colour to DAC
- vga_hs, vga_vs  out  1 each  registered syncs
- active  out  1  registered: pixel on vga_* is in visible area

Behaviour:
- Reset (sync, active high): divider=0, x=0, y=0, pix_en=0, vga_r/g/b=0, vga_hs=vga_vs=~SYNC_POL, active=0. Reset mid-frame takes effect on the next edge with no partial line.
- Divider counts 0..CLK_DIV-1. pix_en=1 when divider==CLK_DIV-1; CLK_DIV=1 gives pix_en=1 every clock after reset.
- On pix_en:
  - If x==H_TOTAL-1, then x<=0 and y advances; otherwise x<=x+1.
  - y advances as y<=(y==V_TOTAL-1)?0:y+1.
- Counters never exceed TOTAL-1. 11-bit width covers totals up to 2047; wider parameters are illegal.
- Combinational decode from current x/y:
  - vis = x<H_ACTIVE && y<V_ACTIVE.
  - hs_on = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_on = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Output register, updated only on pix_en:
  - vga_r/g/b <= vis ? {r,g,b}_in : 0.
  - vga_hs <= hs_on ? SYNC_POL : ~SYNC_POL; vga_vs likewise.
  - active <= vis.
- Latency: colour and syncs appear exactly one pixel period after x/y present that pixel. Syncs are delayed identically, so relative timing is exact.
- Blanking forces black regardless of renderer output.

Optional Feature:
- Macro VGA_SCAN_FRAME_CNT_EN.
- When defined, adds ports frame_start (out, 1) and frame_cnt (out, 16).
  - frame_start pulses for one clock on the pix_en where x and y both wrap to 0.
  - frame_cnt increments on that same edge and wraps at 0xFFFF->0.
  - Both reset to 0.
- When undefined, neither port nor logic exists. All other behaviour is identical.

Decomposition:
- Package vga_scan_pkg holds the default timing constants, derived H_TOTAL/V_TOTAL, and the coordinate width (11).
- One sub-module, vga_axis_counter: a parameterised wrap counter with enable, terminal-count output, and sync-window decode. It is instantiated for horizontal (enable=pix_en) and vertical (enable=pix_en & h terminal).

Test Plan:
- Reset release, CLK_DIV=2 -> x=0,y=0; first pix_en on 2nd clock; x=1 after it; vga_hs=vga_vs=1, rgb=0.
- Run to x=799,y=0, then pix_en -> x=0,y=1. At x=799,y=524, then pix_en -> x=0,y=0.
- Full line scan -> vga_hs low for exactly 96 pixel periods, starting one pixel after x=656. Full frame -> vga_vs low for lines 490..491 (delayed one pixel), i.e. 1600 pixel periods.
- Hold r_in=g_in=b_in=7 -> vga_r=7 one pixel after x=0..639 on y<480. Outputs are 0 and active=0 after x=640..799 and on y>=480.
- Assert rst for one clock at x=300,y=200 -> next edge x=0,y=0, syncs deasserted, rgb=0. Counting resumes normally.
- With VGA_SCAN_FRAME_CNT_EN -> frame_start single-clock pulse every 800*525*2=840000 clocks, and frame_cnt counts 0,1,2.
